// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: drives the columns of a 4x4 key matrix one at a time and samples the rows.
// Presses and releases are debounced over whole scan frames, and each accepted press is reported once.
// Outputs: key_valid is a one-cycle pulse with no back-pressure. key_code is valid while key_valid is high
// and holds its value until the next accepted press.
module keypad_matrix_scanner #(
  parameter int SCAN_HOLD      = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key,
  output logic [1:0] dbg_state_o
);

  localparam int HW = (SCAN_HOLD <= 2) ? 1 : $clog2(SCAN_HOLD);
  localparam int CW = ($clog2(DEBOUNCE_SCANS + 1) < 2) ? 2 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SCAN_HOLD - 1);
  localparam logic [CW-1:0] DEB       = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_PRESSED = 2'd2
  } state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    rows_s;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic          sample, frame_end;
  logic [2:0]    row_cnt, acc_sum;
  logic [1:0]    row_sel;
  logic [1:0]    acc_cnt_q, acc_cnt_d, frame_cnt;
  logic [3:0]    acc_code_q, acc_code_d, frame_code;
  logic          frame_none, frame_one, frame_multi;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d, multi_q, multi_d;
  logic          accept;
  logic [3:0]    accept_code;

  // Two-flop synchroniser for the asynchronous, active-low rows
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= key_row;
      sync2_q <= sync1_q;
    end
  end

  assign rows_s    = ~sync2_q;
  assign sample    = (hold_cnt_q == HOLD_LAST);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign key_col   = ~(4'b0001 << col_idx_q);

  // Column dwell counter and column index stepping
  always_comb begin
    hold_cnt_d = hold_cnt_q + HW'(1);
    col_idx_d  = col_idx_q;
    if (sample) begin
      hold_cnt_d = '0;
      col_idx_d  = col_idx_q + 2'd1;
    end
  end

  // Per-column row statistics and the frame result as of this sample
  always_comb begin
    row_cnt = {2'b00, rows_s[0]} + {2'b00, rows_s[1]} + {2'b00, rows_s[2]} + {2'b00, rows_s[3]};
    row_sel = 2'd0;
    if (rows_s[3]) row_sel = 2'd3;
    if (rows_s[2]) row_sel = 2'd2;
    if (rows_s[1]) row_sel = 2'd1;
    if (rows_s[0]) row_sel = 2'd0;
    acc_sum     = {1'b0, acc_cnt_q} + row_cnt;
    frame_cnt   = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    frame_code  = (row_cnt != 3'd0) ? {col_idx_q, row_sel} : acc_code_q;
    frame_none  = (frame_cnt == 2'd0);
    frame_one   = (frame_cnt == 2'd1);
    frame_multi = (frame_cnt == 2'd2);
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    if (sample) begin
      if (frame_end) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_cnt_d  = frame_cnt;
        acc_code_d = frame_code;
      end
    end
  end

  // Debounce FSM next state and outputs, advanced only on frame-end samples
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    cand_d      = cand_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    held_d      = held_q;
    multi_d     = multi_q;
    accept      = 1'b0;
    accept_code = cand_q;
    if (frame_end) begin
      multi_d = frame_multi;
      case (state_q)
        S_IDLE: begin
          if (frame_one) begin
            if (DEB == CW'(1)) begin
              accept      = 1'b1;
              accept_code = frame_code;
            end else begin
              state_d = S_CONFIRM;
              cand_d  = frame_code;
              cnt_d   = CW'(1);
            end
          end
        end
        S_CONFIRM: begin
          if (frame_one) begin
            if (frame_code == cand_q) begin
              if (cnt_q + CW'(1) == DEB) begin
                accept      = 1'b1;
                accept_code = cand_q;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              cand_d = frame_code;
              cnt_d  = CW'(1);
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (frame_none) begin
            if (rcnt_q + CW'(1) == DEB) begin
              held_d  = 1'b0;
              state_d = S_IDLE;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + CW'(1);
            end
          end else begin
            rcnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        code_d  = accept_code;
        valid_d = 1'b1;
        held_d  = 1'b1;
        state_d = S_PRESSED;
        cnt_d   = '0;
        rcnt_d  = '0;
      end
    end
  end

  // State, scan, accumulator and output registers
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      cand_q     <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      multi_q    <= multi_d;
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench for the key matrix scanner (SCAN_HOLD=4, DEBOUNCE_SCANS=3).
// A small matrix model drives the rows from the column drive. Frame-aligned steps come from a table.
module tb_keypad_matrix_scanner;

  logic        clk_div = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col, key_code;
  logic        key_valid, key_held, multi_key;
  logic [1:0]  dbg_state;
  logic [15:0] keys_down = 16'h0000;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int cyc = 0;
  int p0;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic        valid;
    logic        held;
    logic        multi;
  } step_t;

  step_t steps[$];

  keypad_matrix_scanner #(.SCAN_HOLD(4), .DEBOUNCE_SCANS(3)) dut (
    .clk_div    (clk_div),
    .rst        (rst),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_key  (multi_key),
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk_div = ~clk_div;

  // matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    key_row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys_down[4*c+r] && !key_col[c]) key_row[r] = 1'b0;
  end

  // cycle counter since reset release
  always @(posedge clk_div) begin
    if (rst) cyc = 0;
    else cyc = cyc + 1;
  end

  // pulse monitor
  always @(negedge clk_div) begin
    if (!rst && key_valid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_pulse_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_div);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk_div);
    rst = 1'b0;
    #1;
  endtask

  task automatic add(input logic [15:0] mask, input int frames, input int pulses, input logic [3:0] code,
                     input logic valid, input logic held, input logic multi);
    step_t s;
    s.mask = mask; s.frames = frames; s.pulses = pulses; s.code = code;
    s.valid = valid; s.held = held; s.multi = multi;
    steps.push_back(s);
  endtask

  initial begin
    // expected table: each step starts on a frame boundary
    add(16'h0000, 2, 0, 4'd9, 1'b0, 1'b1, 1'b0);  // two empty frames, still held
    add(16'h0000, 1, 0, 4'd9, 1'b0, 1'b0, 1'b0);  // third empty frame releases
    add(16'h0080, 2, 0, 4'd9, 1'b0, 1'b0, 1'b0);  // col1/row3 confirming
    add(16'h0080, 1, 1, 4'd7, 1'b1, 1'b1, 1'b0);  // accepted, code 7
    add(16'h0000, 2, 0, 4'd7, 1'b0, 1'b1, 1'b0);  // partial release
    add(16'h0080, 3, 0, 4'd7, 1'b0, 1'b1, 1'b0);  // re-press while held: no event
    add(16'h0000, 3, 0, 4'd7, 1'b0, 1'b0, 1'b0);  // full release
    for (int i = 0; i < 5; i++) begin             // bounce: 2 on, 1 off
      add(16'h0200, 2, 0, 4'd7, 1'b0, 1'b0, 1'b0);
      add(16'h0000, 1, 0, 4'd7, 1'b0, 1'b0, 1'b0);
    end
    add(16'h8001, 1, 0, 4'd7, 1'b0, 1'b0, 1'b1);  // two keys, different columns
    add(16'h8001, 2, 0, 4'd7, 1'b0, 1'b0, 1'b1);
    add(16'h0001, 1, 0, 4'd7, 1'b0, 1'b0, 1'b0);  // drop col3/row3
    add(16'h0001, 1, 0, 4'd7, 1'b0, 1'b0, 1'b0);
    add(16'h0001, 1, 1, 4'd0, 1'b1, 1'b1, 1'b0);  // code 0 accepted
    add(16'h0000, 3, 0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(16'h0030, 1, 0, 4'd0, 1'b0, 1'b0, 1'b1);  // two rows in one column
    add(16'h0000, 1, 0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(16'h0020, 1, 0, 4'd0, 1'b0, 1'b0, 1'b0);  // candidate 5
    add(16'h0040, 2, 0, 4'd0, 1'b0, 1'b0, 1'b0);  // switches to candidate 6
    add(16'h0040, 1, 1, 4'd6, 1'b1, 1'b1, 1'b0);
    add(16'h0000, 2, 0, 4'd6, 1'b0, 1'b1, 1'b0);
    add(16'h0041, 1, 0, 4'd6, 1'b0, 1'b1, 1'b1);  // multi while held restarts release count
    add(16'h0000, 2, 0, 4'd6, 1'b0, 1'b1, 1'b0);
    add(16'h0000, 1, 0, 4'd6, 1'b0, 1'b0, 1'b0);

    // reset values and column stepping
    rst = 1'b1;
    cycles(3);
    check("rst_key_col", key_col, 4'b1110);
    check("rst_key_code", key_code, 4'd0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    check("rst_multi_key", multi_key, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    release_rst();
    check("col_c0", key_col, 4'b1110);
    cycles(2);  check("col_c2", key_col, 4'b1110);
    cycles(4);  check("col_c6", key_col, 4'b1101);
    cycles(4);  check("col_c10", key_col, 4'b1011);
    cycles(4);  check("col_c14", key_col, 4'b0111);
    cycles(4);  check("col_c18", key_col, 4'b1110);

    // first press, exact latency, no repeat while held
    rst = 1'b1;
    keys_down = 16'h0200;
    cycles(3);
    release_rst();
    p0 = pulse_cnt;
    cycles(47);
    check("lat_no_early_pulse", pulse_cnt - p0, 0);
    cycles(1);
    check("lat_valid", key_valid, 1'b1);
    check("lat_code", key_code, 4'd9);
    check("lat_held", key_held, 1'b1);
    check("lat_state", dbg_state, 2'd2);
    cycles(1);
    check("lat_valid_drop", key_valid, 1'b0);
    check("lat_pulse_cyc", last_pulse_cyc, 48);
    cycles(159);
    check("hold_one_pulse", pulse_cnt - p0, 1);
    check("hold_held", key_held, 1'b1);

    // table-driven frame steps
    for (int i = 0; i < steps.size(); i++) begin
      keys_down = steps[i].mask;
      p0 = pulse_cnt;
      cycles(16 * steps[i].frames);
      check($sformatf("step%0d_valid", i), key_valid, steps[i].valid);
      check($sformatf("step%0d_code", i), key_code, steps[i].code);
      check($sformatf("step%0d_held", i), key_held, steps[i].held);
      check($sformatf("step%0d_multi", i), multi_key, steps[i].multi);
      check($sformatf("step%0d_pulses", i), pulse_cnt - p0, steps[i].pulses);
    end

    // asynchronous reset during CONFIRM, key kept down
    keys_down = 16'h0200;
    cycles(16);
    check("pre_rst_state", dbg_state, 2'd1);
    cycles(5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_key_col", key_col, 4'b1110);
    check("arst_key_code", key_code, 4'd0);
    check("arst_key_valid", key_valid, 1'b0);
    check("arst_key_held", key_held, 1'b0);
    check("arst_multi_key", multi_key, 1'b0);
    check("arst_state", dbg_state, 2'd0);
    cycles(3);
    release_rst();
    p0 = pulse_cnt;
    cycles(47);
    check("rearm_no_early", pulse_cnt - p0, 0);
    cycles(1);
    check("rearm_valid", key_valid, 1'b1);
    check("rearm_code", key_code, 4'd9);
    cycles(52);
    check("rearm_one_pulse", pulse_cnt - p0, 1);
    check("rearm_pulse_cyc", last_pulse_cyc, 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
